// File: rtl/parity_frame_rx.sv
// Oversampled serial receiver for start / DBITS data (LSB first) / odd parity / stop frames.
// Ports: CLK, RST (async, active-high), RXD (async serial line, idle high);
//        DATA, PERR and FERR hold the last completed frame; VALID pulses once per frame; BUSY is high outside IDLE.
module parity_frame_rx #(
    parameter int OVS   = 4,
    parameter int DBITS = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RXD,
    output logic [DBITS-1:0] DATA,
    output logic             VALID,
    output logic             PERR,
    output logic             FERR,
    output logic             BUSY
);

    localparam int TW = (OVS > 2) ? $clog2(OVS) : 1;
    localparam int CW = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [TW-1:0] T_HALF   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_FULL   = TW'(OVS - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [CW-1:0]    bitcnt, bitcnt_n;
    logic [DBITS-1:0] shreg, shreg_n;
    logic             par_bit, par_bit_n;
    logic [DBITS-1:0] data_n;
    logic             valid_n, perr_n, ferr_n;
    logic             sync1, s_sync;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1  <= 1'b1;
            s_sync <= 1'b1;
        end else begin
            sync1  <= RXD;
            s_sync <= sync1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            DATA    <= '0;
            VALID   <= 1'b0;
            PERR    <= 1'b0;
            FERR    <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            par_bit <= par_bit_n;
            DATA    <= data_n;
            VALID   <= valid_n;
            PERR    <= perr_n;
            FERR    <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        data_n    = DATA;
        valid_n   = 1'b0;
        perr_n    = PERR;
        ferr_n    = FERR;

        case (state)
            ST_IDLE: begin
                if (!s_sync) begin
                    state_n = ST_START;
                    timer_n = '0;
                end
            end
            ST_START: begin
                // Half a bit in: re-check the line to reject glitches.
                if (timer == T_HALF) begin
                    timer_n  = '0;
                    bitcnt_n = '0;
                    state_n  = s_sync ? ST_IDLE : ST_DATA;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_DATA: begin
                if (timer == T_FULL) begin
                    timer_n = '0;
                    // LSB arrives first, so shift toward bit 0.
                    shreg_n = shreg >> 1;
                    shreg_n[DBITS-1] = s_sync;
                    if (bitcnt == LAST_BIT) begin
                        state_n = ST_PARITY;
                    end else begin
                        bitcnt_n = bitcnt + CW'(1);
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_PARITY: begin
                if (timer == T_FULL) begin
                    timer_n   = '0;
                    par_bit_n = s_sync;
                    state_n   = ST_STOP;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_STOP: begin
                if (timer == T_FULL) begin
                    timer_n = '0;
                    data_n  = shreg;
                    // Odd parity: the parity bit should be the XNOR of the data bits.
                    perr_n  = (par_bit != ~(^shreg));
                    ferr_n  = ~s_sync;
                    valid_n = 1'b1;
                    state_n = s_sync ? ST_IDLE : ST_WAIT_IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                // A broken stop bit leaves the line low; wait for idle before hunting for a start.
                if (s_sync) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;

    localparam int OVS   = 4;
    localparam int DBITS = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             RXD;
    logic [DBITS-1:0] DATA;
    logic             VALID;
    logic             PERR;
    logic             FERR;
    logic             BUSY;

    parity_frame_rx #(.OVS(OVS), .DBITS(DBITS)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .RXD   (RXD),
        .DATA  (DATA),
        .VALID (VALID),
        .PERR  (PERR),
        .FERR  (FERR),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        int               at;
        logic [DBITS-1:0] d;
        logic             pe;
        logic             fe;
    } ev_t;

    ev_t              evq[$];
    int               tests = 0;
    int               fails = 0;
    int               nvalid = 0;
    int               last_valid = -1;
    logic [DBITS-1:0] m_data = '0;
    logic             m_perr = 1'b0;
    logic             m_ferr = 1'b0;
    logic             exp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level model: result and arrival cycle follow from the frame contents alone.
    // RXD changes after edge k; two synchronizer edges plus the detecting edge give k+3,
    // then half a bit plus DBITS+2 whole bits until the stop sample.
    function automatic ev_t model_frame(input int k, input logic [DBITS-1:0] d,
                                        input logic p, input logic stp);
        ev_t e;
        int  ones;
        ones = $countones(d) + int'(p);
        e.at = k + 3 + OVS / 2 + (DBITS + 2) * OVS;
        e.d  = d;
        e.pe = (ones % 2 == 0);
        e.fe = ~stp;
        return e;
    endfunction

    // Per-cycle comparison of VALID/DATA/PERR/FERR against the model.
    always @(negedge CLK) begin
        exp_v = 1'b0;
        if (RST) begin
            evq.delete();
            m_data = '0;
            m_perr = 1'b0;
            m_ferr = 1'b0;
            check("reset_hold", {27'd0, VALID, BUSY, PERR, FERR, DATA}, 32'd0);
        end else begin
            if (evq.size() > 0 && evq[0].at == cyc) begin
                exp_v  = 1'b1;
                m_data = evq[0].d;
                m_perr = evq[0].pe;
                m_ferr = evq[0].fe;
                void'(evq.pop_front());
            end
            if (VALID === 1'b1) begin
                nvalid++;
                last_valid = cyc;
            end
            check("cycle_vld_perr_ferr_data", {26'd0, VALID, PERR, FERR, DATA},
                  {26'd0, exp_v, m_perr, m_ferr, m_data});
        end
    end

    // Entered and left just after a rising edge.
    task automatic drive_bit(input logic b);
        RXD = b;
        repeat (OVS) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [DBITS-1:0] d, input logic p, input logic stp,
                              output int k);
        k = cyc;
        evq.push_back(model_frame(k, d, p, stp));
        drive_bit(1'b0);
        for (int i = 0; i < DBITS; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(stp);
        RXD = stp;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int k;
    int kb;
    int n0;

    initial begin
        RST = 1'b0;
        RXD = 1'b1;
        #1 RST = 1'b1;
        #2;
        check("reset_data", {29'd0, DATA}, 32'd0);
        check("reset_valid_perr_ferr_busy", {28'd0, VALID, PERR, FERR, BUSY}, 32'd0);
        idle(3);
        RST = 1'b0;
        idle(3);

        // Good frame 101, parity 1.
        n0 = nvalid;
        send_frame(3'b101, 1'b1, 1'b1, k);
        idle(4);
        check("a_valid_count", nvalid - n0, 1);
        check("a_latency", last_valid - (k + 3), 22);
        check("a_data", {29'd0, DATA}, 32'b101);
        check("a_perr_ferr_busy", {29'd0, PERR, FERR, BUSY}, 32'b000);

        // Parity error frame 011 / parity 0, then a back-to-back good frame 100 / parity 0.
        n0 = nvalid;
        send_frame(3'b011, 1'b0, 1'b1, k);
        idle(1);
        check("b_data", {29'd0, DATA}, 32'b011);
        check("b_perr_ferr", {30'd0, PERR, FERR}, 32'b10);
        send_frame(3'b100, 1'b0, 1'b1, kb);
        idle(4);
        check("b2b_valid_count", nvalid - n0, 2);
        check("b2b_latency", last_valid - (kb + 3), 22);
        check("b2b_data_perr", {28'd0, PERR, DATA}, {28'd0, 1'b0, 3'b100});

        // Framing error: stop bit low and the line kept low 10 more clocks.
        n0 = nvalid;
        send_frame(3'b110, 1'b1, 1'b0, k);
        idle(10);
        check("c_busy_low_line", {31'd0, BUSY}, 32'd1);
        check("c_ferr_perr", {30'd0, FERR, PERR}, 32'b10);
        check("c_data", {29'd0, DATA}, 32'b110);
        RXD = 1'b1;
        idle(2);
        check("c_busy_before_idle", {31'd0, BUSY}, 32'd1);
        idle(1);
        check("c_busy_after_idle", {31'd0, BUSY}, 32'd0);
        idle(6);
        check("c_valid_count", nvalid - n0, 1);

        // One-clock glitch: false start.
        n0 = nvalid;
        RXD = 1'b0;
        idle(1);
        RXD = 1'b1;
        idle(2);
        check("glitch_busy_high", {31'd0, BUSY}, 32'd1);
        idle(2);
        check("glitch_busy_low", {31'd0, BUSY}, 32'd0);
        idle(30);
        check("glitch_no_valid", nvalid - n0, 0);
        check("glitch_data_held", {29'd0, DATA}, 32'b110);

        // Reset during the second data bit, then a clean frame 010 / parity 0.
        n0 = nvalid;
        drive_bit(1'b0);
        drive_bit(1'b1);
        RXD = 1'b0;
        idle(2);
        RST = 1'b1;
        #1;
        check("abort_async_data", {29'd0, DATA}, 32'd0);
        check("abort_async_flags", {28'd0, VALID, PERR, FERR, BUSY}, 32'd0);
        RXD = 1'b1;
        idle(2);
        RST = 1'b0;
        idle(30);
        check("abort_no_valid", nvalid - n0, 0);
        n0 = nvalid;
        send_frame(3'b010, 1'b0, 1'b1, k);
        idle(4);
        check("d_valid_count", nvalid - n0, 1);
        check("d_latency", last_valid - (k + 3), 22);
        check("d_data_perr_ferr", {27'd0, PERR, FERR, DATA}, {27'd0, 1'b0, 1'b0, 3'b010});

        idle(4);
        check("model_queue_drained", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001 SHALL provide parameter: OVS, default 4, clocks per serial bit (even, 4..16).
REQ-002 SHALL provide parameter: DBITS, default 3, data bits per frame (1..8).
REQ-003 SHALL provide port: CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port: RST  in  1  reset; asynchronous and active-high.
REQ-005 SHALL provide port: RXD  in  1  serial line, idle high; asynchronous to CLK.
REQ-006 SHALL provide port: DATA  out  DBITS  last received data word, bit 0 received first.
REQ-007 SHALL provide port: VALID  out  1  one-cycle pulse per completed frame.
REQ-008 SHALL provide port: PERR  out  1  parity error of the last completed frame.
REQ-009 SHALL provide port: FERR  out  1  framing (stop bit) error of the last completed frame.
REQ-010 SHALL provide port: BUSY  out  1  high whenever state is not IDLE.

Function
REQ-011 Frame SHALL be: 1 start bit (0), DBITS data bits LSB first, 1 parity bit, 1 stop bit (1).
REQ-012 Parity SHALL be odd: expected parity = XNOR of all data bits (DBITS=3: ~(d0^d1^d2)); PERR=1 when received parity differs.
REQ-013 RXD SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value S.
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-015 IDLE: S=0 -> START, bit-timer cleared to 0.
REQ-016 START: sample S when timer reaches OVS/2-1; S=1 -> IDLE (false start, no VALID); S=0 -> DATA, timer cleared.
REQ-017 DATA/PARITY/STOP: sample S when timer reaches OVS-1, i.e. every OVS clocks after the previous sample; timer clears at each sample.
REQ-018 DATA SHALL shift DBITS samples into an internal register, then -> PARITY; PARITY samples one bit, then -> STOP.
REQ-019 At the stop sample edge: DATA, PERR, FERR SHALL load, and VALID SHALL be 1 for the following cycle only.
REQ-020 Stop sample S=1 -> IDLE, FERR=0; S=0 -> WAIT_IDLE, FERR=1.
REQ-021 WAIT_IDLE SHALL remain until S=1, then -> IDLE; no start detection while in WAIT_IDLE.
REQ-022 VALID SHALL assert for every completed frame regardless of PERR/FERR.
REQ-023 DATA, PERR and FERR SHALL hold their values between VALID pulses.
REQ-024 Latency: VALID SHALL rise exactly OVS/2 + (DBITS+2)*OVS clocks after the edge on which IDLE sees S=0 (22 for defaults).
REQ-025 Back-to-back frames SHALL be received: a start bit immediately following a good stop bit is detected from IDLE.

Reset
REQ-026 RST=1 SHALL immediately force: state IDLE, timer 0, shift register 0, synchronizer 1, DATA=0, VALID=0, PERR=0, FERR=0, BUSY=0.
REQ-027 RST asserted mid-frame SHALL discard the partial frame; no VALID SHALL be produced for it.
REQ-028 After RST deasserts, the first S=0 seen in IDLE SHALL start a new frame.

Verification (OVS=4, DBITS=3)
REQ-029 Verification SHALL cover: RST pulse with RXD=1 -> DATA=000, VALID=0, PERR=0, FERR=0, BUSY=0, asynchronously.
REQ-030 Verification SHALL cover: frame 0,1,0,1,1,1 (start, data 101, parity 1, stop) -> VALID once, 22 clocks after detection, DATA=101, PERR=0, FERR=0.
REQ-031 Verification SHALL cover: frame data 011 with parity 0 -> VALID, DATA=011, PERR=1, FERR=0.
REQ-032 Verification SHALL cover: frame data 110 with parity 1 and stop 0, line held low 10 more clocks -> VALID, FERR=1, BUSY=1 until S=1, no second frame started.
REQ-033 Verification SHALL cover: RXD low for 1 clock, then high -> BUSY pulses, returns to IDLE, no VALID.
REQ-034 Verification SHALL cover: RST asserted during 2nd data bit, released, then frame data 010 parity 0 -> no VALID for the aborted frame; one VALID with DATA=010, PERR=0.
